// File: rtl/sipo_pkg.sv
// Shared types and sizing for the serial-in parallel-out frame assembler.
package sipo_pkg;

  localparam int W_DEF = 4;
  localparam int N_DEF = 4;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_width(N_DEF);

  typedef logic [N_DEF-1:0][W_DEF-1:0] frame_t;

endpackage

// File: rtl/sipo_register_if.sv
// Serial word input and parallel frame output of the SIPO register.
interface sipo_register_if
  import sipo_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
);

  logic [W-1:0]              sin;
  logic                      sin_valid;
  logic                      sin_ready;
  logic [N*W-1:0]            pout;
  logic                      pout_valid;
  logic                      pout_ready;
  logic [cnt_width(N)-1:0]   fill_cnt;

  modport master (
    output sin, sin_valid, pout_ready,
    input  sin_ready, pout, pout_valid, fill_cnt
  );

  modport slave (
    input  sin, sin_valid, pout_ready,
    output sin_ready, pout, pout_valid, fill_cnt
  );

endinterface

// File: rtl/sipo_shift_buf.sv
// N-stage W-bit shift chain; new words enter at the top stage, oldest word ends in stage 0.
module sipo_shift_buf #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_en_i,
  input  logic [W-1:0]        din_i,
  output logic [N-1:0][W-1:0] stages_o
);

  logic [N-1:0][W-1:0] stages_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stages_q <= '0;
    end else if (shift_en_i) begin
      for (int i = 0; i < N - 1; i++) begin
        stages_q[i] <= stages_q[i+1];
      end
      stages_q[N-1] <= din_i;
    end
  end

  assign stages_o = stages_q;

endmodule

// File: rtl/sipo_register.sv
// Assembles N serial W-bit words into one frame and presents it with valid/ready.
module sipo_register
  import sipo_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input  logic            clk,
  input  logic            reset,
  sipo_register_if.slave  bus
);

  localparam int CW = cnt_width(N);

  typedef logic [N-1:0][W-1:0] lanes_t;

  lanes_t          stages;
  lanes_t          shifted;
  lanes_t          pout_q, pout_d;
  logic [CW-1:0]   fill_cnt_q, fill_cnt_d;
  logic            pout_valid_q, pout_valid_d;
  logic            accept, out_free, last_word, stalled, load;

  assign bus.sin_ready = (fill_cnt_q != CW'(N));
  assign accept        = bus.sin_valid && bus.sin_ready;
  assign out_free      = !pout_valid_q || bus.pout_ready;
  assign last_word     = accept && (fill_cnt_q == CW'(N - 1));
  assign stalled       = (fill_cnt_q == CW'(N));
  assign load          = out_free && (last_word || stalled);

  sipo_shift_buf #(
    .W (W),
    .N (N)
  ) u_shift_buf (
    .clk        (clk),
    .reset      (reset),
    .shift_en_i (accept),
    .din_i      (bus.sin),
    .stages_o   (stages)
  );

  // Frame as it will look after the current word shifts in, so the last word
  // can go straight to the output without a stall cycle.
  always_comb begin
    shifted = stages;
    for (int i = 0; i < N - 1; i++) begin
      shifted[i] = stages[i+1];
    end
    shifted[N-1] = bus.sin;
  end

  always_comb begin
    fill_cnt_d   = fill_cnt_q;
    pout_valid_d = pout_valid_q;
    pout_d       = pout_q;
    if (load) begin
      fill_cnt_d   = '0;
      pout_valid_d = 1'b1;
      pout_d       = stalled ? stages : shifted;
    end else begin
      if (accept) begin
        fill_cnt_d = fill_cnt_q + CW'(1);
      end
      if (bus.pout_ready) begin
        pout_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt_q   <= '0;
      pout_valid_q <= 1'b0;
      pout_q       <= '0;
    end else begin
      fill_cnt_q   <= fill_cnt_d;
      pout_valid_q <= pout_valid_d;
      pout_q       <= pout_d;
    end
  end

  assign bus.pout       = pout_q;
  assign bus.pout_valid = pout_valid_q;
  assign bus.fill_cnt   = fill_cnt_q;

endmodule

// File: tb/tb_sipo_register.sv
// Directed checks of frame assembly, backpressure, gaps, async reset and drain/load overlap.
module tb_sipo_register;
  import sipo_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] delivered[$];

  sipo_register_if #(.W(4), .N(4)) bus ();

  sipo_register #(.W(4), .N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Record every frame the consumer actually takes.
  always @(posedge clk) begin
    if (!reset && bus.pout_valid && bus.pout_ready) delivered.push_back(bus.pout);
  end

  task automatic send(input logic [3:0] w);
    bus.sin       = w;
    bus.sin_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.sin_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset          = 1'b1;
    bus.sin        = '0;
    bus.sin_valid  = 1'b0;
    bus.pout_ready = 1'b0;
    #12;
    checks++; if (bus.fill_cnt !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", bus.fill_cnt); end
    checks++; if (bus.pout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.pout_valid); end
    checks++; if (bus.pout !== 16'h0000) begin errors++; $display("FAIL reset_pout got %h exp 0000", bus.pout); end
    reset = 1'b0;
    idle(1);
    checks++; if (bus.sin_ready !== 1'b1) begin errors++; $display("FAIL reset_sin_ready got %b exp 1", bus.sin_ready); end
  endtask

  task automatic test_single_frame;
    bus.pout_ready = 1'b1;
    send(4'h1); send(4'h2); send(4'h3);
    checks++; if (bus.pout_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", bus.pout_valid); end
    checks++; if (bus.fill_cnt !== 3'd3) begin errors++; $display("FAIL single_fill3 got %0d exp 3", bus.fill_cnt); end
    send(4'h4);
    checks++; if (bus.pout !== 16'h4321) begin errors++; $display("FAIL single_pout got %h exp 4321", bus.pout); end
    checks++; if (bus.pout_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.pout_valid); end
    checks++; if (bus.fill_cnt !== 3'd0) begin errors++; $display("FAIL single_fill0 got %0d exp 0", bus.fill_cnt); end
    idle(1);
    checks++; if (bus.pout_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", bus.pout_valid); end
  endtask

  task automatic test_back_to_back;
    int drops = 0;
    bus.pout_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (bus.sin_ready !== 1'b1) drops++;
      send(4'(i));
      if (i == 4) begin
        checks++; if (bus.pout !== 16'h4321 || bus.pout_valid !== 1'b1) begin errors++; $display("FAIL b2b_frame1 got %h/%b exp 4321/1", bus.pout, bus.pout_valid); end
      end
    end
    checks++; if (bus.pout !== 16'h8765 || bus.pout_valid !== 1'b1) begin errors++; $display("FAIL b2b_frame2 got %h/%b exp 8765/1", bus.pout, bus.pout_valid); end
    checks++; if (drops !== 0) begin errors++; $display("FAIL b2b_sin_ready_drops got %0d exp 0", drops); end
    idle(1);
  endtask

  task automatic test_stall;
    bus.pout_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(4'(i));
    checks++; if (bus.fill_cnt !== 3'd4) begin errors++; $display("FAIL stall_fill got %0d exp 4", bus.fill_cnt); end
    checks++; if (bus.sin_ready !== 1'b0) begin errors++; $display("FAIL stall_sin_ready got %b exp 0", bus.sin_ready); end
    bus.sin = 4'hF; bus.sin_valid = 1'b1;
    idle(2);
    bus.sin_valid = 1'b0;
    checks++; if (bus.pout !== 16'h4321 || bus.pout_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got %h/%b exp 4321/1", bus.pout, bus.pout_valid); end
    bus.pout_ready = 1'b1;
    idle(1);
    checks++; if (bus.pout !== 16'h8765 || bus.pout_valid !== 1'b1) begin errors++; $display("FAIL stall_release got %h/%b exp 8765/1", bus.pout, bus.pout_valid); end
    checks++; if (bus.sin_ready !== 1'b1 || bus.fill_cnt !== 3'd0) begin errors++; $display("FAIL stall_resume got %b/%0d exp 1/0", bus.sin_ready, bus.fill_cnt); end
    idle(1);
  endtask

  task automatic test_gaps;
    bus.pout_ready = 1'b1;
    send(4'hA);
    idle(3);
    checks++; if (bus.fill_cnt !== 3'd1) begin errors++; $display("FAIL gap_fill1 got %0d exp 1", bus.fill_cnt); end
    send(4'hB);
    idle(3);
    checks++; if (bus.fill_cnt !== 3'd2) begin errors++; $display("FAIL gap_fill2 got %0d exp 2", bus.fill_cnt); end
    send(4'hC); send(4'hD);
    checks++; if (bus.pout !== 16'hDCBA || bus.pout_valid !== 1'b1) begin errors++; $display("FAIL gap_frame got %h/%b exp dcba/1", bus.pout, bus.pout_valid); end
    idle(1);
  endtask

  task automatic test_async_reset;
    bus.pout_ready = 1'b0;
    send(4'h9); send(4'hA); send(4'hB); send(4'hC);
    send(4'h1); send(4'h2); send(4'h3);
    #3 reset = 1'b1;
    #1;
    checks++; if (bus.fill_cnt !== 3'd0) begin errors++; $display("FAIL areset_fill got %0d exp 0", bus.fill_cnt); end
    checks++; if (bus.pout_valid !== 1'b0 || bus.pout !== 16'h0000) begin errors++; $display("FAIL areset_out got %h/%b exp 0000/0", bus.pout, bus.pout_valid); end
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    bus.pout_ready = 1'b1;
    send(4'h5); send(4'h6); send(4'h7); send(4'h8);
    checks++; if (bus.pout !== 16'h8765 || bus.pout_valid !== 1'b1) begin errors++; $display("FAIL areset_frame got %h/%b exp 8765/1", bus.pout, bus.pout_valid); end
    idle(1);
  endtask

  task automatic test_drain_and_load;
    delivered.delete();
    bus.pout_ready = 1'b0;
    send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    send(4'h5); send(4'h6); send(4'h7);
    bus.pout_ready = 1'b1;
    send(4'h8);
    checks++; if (bus.pout !== 16'h8765 || bus.pout_valid !== 1'b1) begin errors++; $display("FAIL overlap_load got %h/%b exp 8765/1", bus.pout, bus.pout_valid); end
    checks++; if (bus.fill_cnt !== 3'd0) begin errors++; $display("FAIL overlap_fill got %0d exp 0", bus.fill_cnt); end
    idle(2);
    checks++; if (bus.pout_valid !== 1'b0) begin errors++; $display("FAIL overlap_drain got %b exp 0", bus.pout_valid); end
    checks++;
    if (delivered.size() !== 2) begin
      errors++; $display("FAIL overlap_count got %0d exp 2", delivered.size());
    end else if (delivered[0] !== 16'h4321 || delivered[1] !== 16'h8765) begin
      errors++; $display("FAIL overlap_order got %h,%h exp 4321,8765", delivered[0], delivered[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_gaps();
    test_async_reset();
    test_drain_and_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
